// File: rtl/cv32e40x_illegal_trace_buf_pkg.sv
// Shared types and constants for the illegal-instruction trace buffer.
// The optional event printout is enabled with CV32E40X_TRACE_BUF_DISPLAY_EN.
package cv32e40x_illegal_trace_buf_pkg;

  localparam int TRACE_MAX_PORTS = 4;
  localparam int TRACE_PORT_W    = 2;

  // Timestamp-independent part of a trace entry; the owner appends its own timestamp.
  typedef struct packed {
    logic [31:0]             pc;
    logic [TRACE_PORT_W-1:0] port;
  } trace_hdr_t;

  function automatic int port_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/cv32e40x_illegal_trace_buf_if.sv
// Drain port of the trace buffer: head entry with a valid/ready handshake.
interface cv32e40x_illegal_trace_buf_if
  import cv32e40x_illegal_trace_buf_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int TS_WIDTH  = 32
);
  localparam int PW = port_width(NUM_PORTS);

  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [31:0]         rd_pc_o;
  logic [PW-1:0]       rd_port_o;
  logic [TS_WIDTH-1:0] rd_time_o;

  modport master (output rd_valid_o, rd_pc_o, rd_port_o, rd_time_o, input rd_ready_i);
  modport slave  (input rd_valid_o, rd_pc_o, rd_port_o, rd_time_o, output rd_ready_i);

endinterface

// File: rtl/cv32e40x_illegal_trace_buf_fifo.sv
// Circular FIFO accepting up to MAX_PUSH ordered entries per cycle and popping one.
module cv32e40x_illegal_trace_buf_fifo #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int MAX_PUSH = 1,
  parameter int CW       = 3,
  parameter int LW       = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [CW-1:0]                    push_cnt,
  input  logic [MAX_PUSH-1:0][WIDTH-1:0]   push_data,
  input  logic                             pop,
  output logic [LW-1:0]                    level,
  output logic [WIDTH-1:0]                 head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // The caller never pushes more than the free space, so pointer sums wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      for (int i = 0; i < MAX_PUSH; i++) begin
        if (i < 32'(push_cnt)) begin
          mem[wptr + AW'(i)] <= push_data[i];
        end
      end
      wptr  <= wptr + AW'(push_cnt);
      rptr  <= rptr + AW'(pop);
      level <= level + LW'(push_cnt) - LW'(pop);
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/cv32e40x_illegal_trace_buf.sv
// Illegal-instruction retire trace buffer with counters and a drain port.
// Define CV32E40X_TRACE_BUF_DISPLAY_EN to print captured and dropped events.
module cv32e40x_illegal_trace_buf
  import cv32e40x_illegal_trace_buf_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int DEPTH     = 16,
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          freeze_i,
  input  logic [NUM_PORTS-1:0]          ev_valid_i,
  input  logic [NUM_PORTS-1:0]          ev_illegal_i,
  input  logic [NUM_PORTS*32-1:0]       ev_pc_i,
  input  logic [31:0]                   mhartid_i,
  cv32e40x_illegal_trace_buf_if.master  rd,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic [CNT_WIDTH-1:0]          illegal_cnt_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o,
  output logic                          overflow_o
);

  localparam int PW = port_width(NUM_PORTS);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = 3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_chk
    $error("DEPTH must be a power of two and at least 2");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > TRACE_MAX_PORTS) begin : gen_ports_chk
    $error("NUM_PORTS must be within 1..4");
  end

  typedef struct packed {
    trace_hdr_t          hdr;
    logic [TS_WIDTH-1:0] ts;
  } trace_entry_t;

  localparam int EW = $bits(trace_entry_t);

  logic [TS_WIDTH-1:0]               ts_q;
  logic [NUM_PORTS-1:0]              events;
  logic [NUM_PORTS-1:0]              capture;
  logic [NUM_PORTS-1:0]              drop;
  trace_entry_t [NUM_PORTS-1:0]      push_data;
  logic [31:0]                       space;
  logic [31:0]                       n_push;
  logic [31:0]                       n_drop;
  logic [CW-1:0]                     push_cnt;
  logic [CW-1:0]                     drop_total;
  logic [CW-1:0]                     ev_total;
  logic [LW-1:0]                     level;
  trace_entry_t                      head;
  logic                              rd_valid;
  logic                              pop;
  logic                              unused_ok;

  assign events = ev_valid_i & ev_illegal_i & {NUM_PORTS{~freeze_i}};

  // Accept events lowest channel first into the space left at the start of the
  // cycle; a same-cycle pop does not make room, so the remainder is dropped.
  always_comb begin
    space     = 32'(DEPTH) - 32'(level);
    n_push    = '0;
    n_drop    = '0;
    capture   = '0;
    drop      = '0;
    push_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (events[k]) begin
        if (n_push < space) begin
          capture[k] = 1'b1;
          for (int s = 0; s < NUM_PORTS; s++) begin
            if (32'(s) == n_push) begin
              push_data[s].hdr.pc   = ev_pc_i[32*k +: 32];
              push_data[s].hdr.port = TRACE_PORT_W'(k);
              push_data[s].ts       = ts_q;
            end
          end
          n_push = n_push + 32'd1;
        end else begin
          drop[k] = 1'b1;
          n_drop  = n_drop + 32'd1;
        end
      end
    end
    push_cnt   = clear_i ? '0 : CW'(n_push);
    drop_total = CW'(n_drop);
    ev_total   = CW'(n_push + n_drop);
  end

  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd.rd_ready_i & ~clear_i;

  cv32e40x_illegal_trace_buf_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (EW),
    .MAX_PUSH (NUM_PORTS),
    .CW       (CW),
    .LW       (LW)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (pop),
    .level     (level),
    .head      (head)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CW-1:0] b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // The timestamp free-runs through clear; only reset restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q          <= '0;
      illegal_cnt_o <= '0;
      drop_cnt_o    <= '0;
      overflow_o    <= 1'b0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clear_i) begin
        illegal_cnt_o <= '0;
        drop_cnt_o    <= '0;
        overflow_o    <= 1'b0;
      end else begin
        illegal_cnt_o <= sat_add(illegal_cnt_o, ev_total);
        drop_cnt_o    <= sat_add(drop_cnt_o, drop_total);
        if (drop_total != '0) begin
          overflow_o <= 1'b1;
        end
      end
    end
  end

  assign level_o       = level;
  assign rd.rd_valid_o = rd_valid;
  assign rd.rd_pc_o    = rd_valid ? head.hdr.pc : '0;
  assign rd.rd_port_o  = rd_valid ? head.hdr.port[PW-1:0] : '0;
  assign rd.rd_time_o  = rd_valid ? head.ts : '0;

  assign unused_ok = ^{mhartid_i, head.hdr.port};

`ifdef CV32E40X_TRACE_BUF_DISPLAY_EN
`ifndef FORMAL
  always @(negedge clk_i) begin
    if (!rst_i && !clear_i) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (capture[k]) begin
          $display("%0t: Illegal instruction (core %0d, port %0d) at PC 0x%08x",
                   $time, mhartid_i[3:0], k, ev_pc_i[32*k +: 32]);
        end else if (drop[k]) begin
          $display("%0t: trace dropped (core %0d, port %0d) at PC 0x%08x",
                   $time, mhartid_i[3:0], k, ev_pc_i[32*k +: 32]);
        end
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_cv32e40x_illegal_trace_buf.sv
// Randomised and directed bench comparing the trace buffer against a queue-based model.
module tb_cv32e40x_illegal_trace_buf;

  localparam int NUM_PORTS = 2;
  localparam int DEPTH     = 4;
  localparam int TS_WIDTH  = 32;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic                    clear_i;
  logic                    freeze_i;
  logic [NUM_PORTS-1:0]    ev_valid_i;
  logic [NUM_PORTS-1:0]    ev_illegal_i;
  logic [NUM_PORTS*32-1:0] ev_pc_i;
  logic [31:0]             mhartid_i;
  logic [$clog2(DEPTH):0]  level_o;
  logic [CNT_WIDTH-1:0]    illegal_cnt_o;
  logic [CNT_WIDTH-1:0]    drop_cnt_o;
  logic                    overflow_o;

  cv32e40x_illegal_trace_buf_if #(.NUM_PORTS(NUM_PORTS), .TS_WIDTH(TS_WIDTH)) rd_if ();

  cv32e40x_illegal_trace_buf #(
    .NUM_PORTS (NUM_PORTS),
    .DEPTH     (DEPTH),
    .TS_WIDTH  (TS_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .freeze_i      (freeze_i),
    .ev_valid_i    (ev_valid_i),
    .ev_illegal_i  (ev_illegal_i),
    .ev_pc_i       (ev_pc_i),
    .mhartid_i     (mhartid_i),
    .rd            (rd_if.master),
    .level_o       (level_o),
    .illegal_cnt_o (illegal_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          port;
    logic [31:0] ts;
  } ent_t;

  ent_t        model_q[$];
  int          model_ill;
  int          model_drop;
  bit          model_ovf;
  logic [31:0] model_ts;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] illegal,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input bit ready, input bit freeze, input bit clear, input bit reset);
    ev_valid_i         = valid;
    ev_illegal_i       = illegal;
    ev_pc_i            = {pc1, pc0};
    rd_if.rd_ready_i   = ready;
    freeze_i           = freeze;
    clear_i            = clear;
    rst_i              = reset;
  endtask

  task automatic compareAll();
    bit          v;
    v = (model_q.size() != 0);
    checkOutput("rd_valid", 64'(rd_if.rd_valid_o), 64'(v));
    checkOutput("rd_pc",    64'(rd_if.rd_pc_o),    v ? 64'(model_q[0].pc) : 64'd0);
    checkOutput("rd_port",  64'(rd_if.rd_port_o),  v ? 64'(model_q[0].port) : 64'd0);
    checkOutput("rd_time",  64'(rd_if.rd_time_o),  v ? 64'(model_q[0].ts) : 64'd0);
    checkOutput("level",    64'(level_o),          64'(model_q.size()));
    checkOutput("ill_cnt",  64'(illegal_cnt_o),    64'(model_ill));
    checkOutput("drop_cnt", 64'(drop_cnt_o),       64'(model_drop));
    checkOutput("overflow", 64'(overflow_o),       64'(model_ovf));
  endtask

  // Check the current state, advance the model by the rules, then clock the DUT.
  task automatic stepCycle(input bit do_check);
    int   room;
    int   n_ev;
    bit   do_pop;
    ent_t e;
    if (do_check) compareAll();
    if (rst_i) begin
      model_q.delete();
      model_ill  = 0;
      model_drop = 0;
      model_ovf  = 0;
      model_ts   = 0;
    end else if (clear_i) begin
      model_q.delete();
      model_ill  = 0;
      model_drop = 0;
      model_ovf  = 0;
      model_ts   = model_ts + 1;
    end else begin
      room   = DEPTH - model_q.size();
      do_pop = (model_q.size() != 0) && rd_if.rd_ready_i;
      n_ev   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (ev_valid_i[k] && ev_illegal_i[k] && !freeze_i) begin
          n_ev++;
          if (room > 0) begin
            e.pc   = ev_pc_i[32*k +: 32];
            e.port = k;
            e.ts   = model_ts;
            model_q.push_back(e);
            room--;
          end else begin
            model_drop = (model_drop < CNT_MAX) ? model_drop + 1 : CNT_MAX;
            model_ovf  = 1;
          end
        end
      end
      model_ill = (model_ill + n_ev > CNT_MAX) ? CNT_MAX : model_ill + n_ev;
      if (do_pop) void'(model_q.pop_front());
      model_ts = model_ts + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return $urandom & 32'hffff_fffc;
  endfunction

  initial begin
    mhartid_i = 32'd3;
    model_ts  = 0;
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    stepCycle(0);
    stepCycle(0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    compareAll();

    // Single event at pc 0x100 in cycle 5 after reset release.
    for (int i = 0; i < 5; i++) stepCycle(1);
    applyStimulus(2'b01, 2'b01, 32'h100, 0, 0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_time", 64'(rd_if.rd_time_o), 64'd5);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
    stepCycle(1);

    // Simultaneous events on both channels, drained in order.
    applyStimulus(2'b11, 2'b11, 32'h200, 32'h300, 0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) stepCycle(1);

    // Overflow: six events into a four-entry FIFO, then pop while full with two events.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 0, 0, 0, 0);
      stepCycle(1);
    end
    applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 1, 0, 0, 0);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("pop_full_level", 64'(level_o), 64'd3);

    // Backpressure: head must stay put for ten cycles.
    for (int i = 0; i < 10; i++) stepCycle(1);

    // Clear with level 3 and an event in the same cycle.
    applyStimulus(2'b01, 2'b01, rand_pc(), 0, 1, 0, 1, 0);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("clear_level", 64'(level_o), 64'd0);

    // Freeze suppresses capture and counting.
    applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) stepCycle(1);

    // Pointer wrap: repeated push/pop pairs.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      applyStimulus(2'b01, 2'b01, rand_pc(), 0, 1, 0, 0, 0);
      stepCycle(1);
    end

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(2'($urandom), 2'($urandom | $urandom), rand_pc(), rand_pc(),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 39) == 0), 0);
      stepCycle(1);
    end

    // Reset in the middle of draining.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 1, 0, 0, 0);
      stepCycle(1);
    end
    applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 1, 0, 0, 1);
    stepCycle(1);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_time", 64'(rd_if.rd_time_o), 64'd0);
    stepCycle(1);

    // Saturation of both counters.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(2'b11, 2'b11, rand_pc(), rand_pc(), 0, 0, 0, 0);
      stepCycle(1);
    end
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    checkOutput("ill_sat",  64'(illegal_cnt_o), 64'(CNT_MAX));
    checkOutput("drop_sat", 64'(drop_cnt_o),    64'(CNT_MAX));
    stepCycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40x_illegal_trace_buf.md
Name: cv32e40x_illegal_trace_buf

Overview:
Parametrised successor to the core simulation logger. Captures illegal-instruction retire events from NUM_PORTS retire channels into a circular trace FIFO, keeping the PC, channel index and a cycle timestamp for each event. Provides event counters and a valid/ready drain port for a debug or trace consumer. Sits beside the core, fed from the EX/WB retire signals of each channel.

Parameters:
NUM_PORTS, 1, number of retire channels monitored (1..4)
DEPTH, 16, trace FIFO entries; power of two, >=2
TS_WIDTH, 32, width of the free-running cycle timestamp
CNT_WIDTH, 16, width of the illegal and drop counters

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous flush of the FIFO, counters and overflow flag; the timestamp is not cleared
freeze_i  in  1  when high, no new events are captured or counted
ev_valid_i  in  NUM_PORTS  per-channel retire valid
ev_illegal_i  in  NUM_PORTS  per-channel illegal-instruction flag
ev_pc_i  in  NUM_PORTS*32  per-channel PC; channel k occupies bits [32k+31:32k]
mhartid_i  in  32  hart id, used only by the optional display
rd_valid_o  out  1  head entry is available
rd_ready_i  in  1  consumer accepts the head entry
rd_pc_o  out  32  head entry PC
rd_port_o  out  PW  head entry channel; PW = max(1, $clog2(NUM_PORTS))
rd_time_o  out  TS_WIDTH  head entry timestamp
level_o  out  $clog2(DEPTH)+1  current occupancy
illegal_cnt_o  out  CNT_WIDTH  events seen (captured + dropped), saturating
drop_cnt_o  out  CNT_WIDTH  events lost because the FIFO was full, saturating
overflow_o  out  1  sticky, set on the first drop

Behaviour:
- Event on channel k in a cycle: ev_valid_i[k] && ev_illegal_i[k] && !freeze_i.
- Reset (rst_i): FIFO empty, pointers 0, both counters 0, overflow_o 0, timestamp 0.
  - All rd_* outputs are 0.
  - rst_i has priority over clear_i and over any in-flight event.
- Timestamp: increments by 1 every cycle after reset and wraps modulo 2^TS_WIDTH. An event captured in cycle N stores the timestamp value present in cycle N.
- Capture in one cycle:
  - Up to NUM_PORTS events are written in ascending channel order.
  - Free space for writes is DEPTH minus the level at the start of the cycle. A pop in the same cycle does not free a slot until the next cycle.
  - Events beyond the free space are dropped, highest channel indices first. Each drop increments drop_cnt_o and sets overflow_o.
- Counters:
  - illegal_cnt_o increases by the total event count for the cycle (0..NUM_PORTS).
  - Both counters saturate at all-ones and never wrap.
- Latency:
  - An event written into an empty FIFO in cycle N gives rd_valid_o=1 in cycle N+1.
  - rd_* fields are driven combinationally from the head storage entry.
- Drain:
  - A pop occurs when rd_valid_o && rd_ready_i; the head advances next cycle.
  - rd_pc_o, rd_port_o and rd_time_o hold stable while rd_valid_o && !rd_ready_i.
  - When empty, rd_valid_o=0 and the data fields read as 0.
- Pointers: wrap modulo DEPTH. level_o at the next cycle = level + pushes - pop.
- clear_i: next cycle the FIFO is empty, both counters are 0 and overflow_o is 0. Events and pops in the clear cycle are discarded.
- freeze_i: suppresses capture and counting only. Draining continues.
- Parameter checks: elaboration-time assertions for DEPTH a power of two and 1 <= NUM_PORTS <= 4.

Optional Feature:
- Macro CV32E40X_TRACE_BUF_DISPLAY_EN.
- Defined: on the falling clock edge, each captured event prints "<time>: Illegal instruction (core <mhartid_i[3:0]>, port <k>) at PC 0x<pc>". Each drop prints a "trace dropped" line.
- Undefined: no $display code is present and the RTL is fully synthesizable.
- The display code is always excluded under FORMAL.

Decomposition:
- cv32e40x_pkg gains:
  - trace_entry_t struct {pc[31:0], port[1:0], time}, parameterised by TS_WIDTH through the module's local copy;
  - constant TRACE_MAX_PORTS = 4.
- One natural sub-module: cv32e40x_trace_fifo, a multi-push single-pop circular FIFO.
  - Inputs: push count, ordered entries, pop.
  - Outputs: level and head.
- The top level contains the event qualification, counters, timestamp and display code.

Test Plan:
1. NUM_PORTS=1, DEPTH=4. After reset, one event at pc 0x0000_0100 in cycle 5 -> cycle 6: rd_valid_o=1, rd_pc_o=0x100, rd_port_o=0, rd_time_o=5, illegal_cnt_o=1.
2. NUM_PORTS=2, simultaneous events pc 0x200 on port 0 and 0x300 on port 1 -> drained in order 0x200/port0 then 0x300/port1, same timestamp, level_o=2 then 1 then 0.
3. DEPTH=4, rd_ready_i=0, six events -> level_o=4, drop_cnt_o=2, illegal_cnt_o=6, overflow_o=1. Pop while full with 2 events in the same cycle -> both dropped, level_o=3.
4. Backpressure: rd_ready_i held low 10 cycles -> head fields stable. Pointer wrap after 3×DEPTH push/pop pairs -> data order preserved.
5. clear_i with level_o=3 and an event in the same cycle -> next cycle level_o=0, counters 0, overflow_o=0. freeze_i=1 with events -> no change to the FIFO or counters.
6. rst_i mid-drain -> all outputs 0 next cycle. Force counters near all-ones -> saturate at 0xFFFF for CNT_WIDTH=16.
